// File: rtl/imem_backing_ctrl.sv
// imem_backing_ctrl: memory-side responder for the instruction-cache refill
// port. Accepts one request at a time, waits a fixed LATENCY, then returns
// one word from a word-addressed backing store with a single-cycle strobe.
// A side write port patches the store in any state.
module imem_backing_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    WORD_SIZE  = 4,
  parameter int                    NUM_WORDS  = 1024,
  parameter int                    LATENCY    = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_BASE  = 32'h10000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_instr,
  output logic                  mem_instr_valid,
  output logic                  busy,
  output logic                  err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [31:0]           req_count
);

  // Byte-offset bits dropped from addresses, full word-index width, and the
  // number of index bits that actually address the store.
  localparam int OFF   = $clog2(WORD_SIZE);
  localparam int IDX_W = ADDR_WIDTH - OFF;
  localparam int AW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [IDX_W:0] NUM_WORDS_W = (IDX_W + 1)'(NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Packed store image so the power-on contents can come from a function.
  typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] store_t;

  function automatic store_t init_store();
    store_t v;
    for (int i = 0; i < NUM_WORDS; i++) begin
      v[i] = INIT_BASE + DATA_WIDTH'(i);
    end
    return v;
  endfunction

  // Contents are set once at time zero; reset never touches them.
  store_t mem_reg = init_store();

  state_t          state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [AW-1:0]    idx_reg;
  logic             in_range_reg;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             req_in_range;
  logic             wr_in_range;

  assign req_idx      = mem_addr[ADDR_WIDTH-1:OFF];
  assign wr_idx       = wr_addr[ADDR_WIDTH-1:OFF];
  assign req_in_range = ({1'b0, req_idx} < NUM_WORDS_W);
  assign wr_in_range  = ({1'b0, wr_idx} < NUM_WORDS_W);

  // Sub-word address bits carry no information: any byte in a word returns
  // the containing word.
  generate
    if (OFF > 0) begin : g_unused_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^{mem_addr[OFF-1:0], wr_addr[OFF-1:0]};
    end
  endgenerate

  // Side write port; out-of-range writes are dropped. Non-blocking update
  // gives read-before-write against a response read on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem_reg[wr_idx[AW-1:0]] <= wr_data;
    end
  end

  // Request FSM with registered outputs: accept, count down, respond once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      in_range_reg    <= 1'b0;
      mem_instr       <= '0;
      mem_instr_valid <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
      req_count       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          mem_instr_valid <= 1'b0;
          err             <= 1'b0;
          if (mem_req) begin
            idx_reg      <= req_idx[AW-1:0];
            in_range_reg <= req_in_range;
            cnt_reg      <= CNT_LOAD;
            req_count    <= req_count + 32'd1;
            busy         <= 1'b1;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            mem_instr       <= in_range_reg ? mem_reg[idx_reg] : '0;
            err             <= ~in_range_reg;
            mem_instr_valid <= 1'b1;
            state_reg       <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          // mem_req is still held by the cache here, so it is not sampled.
          mem_instr_valid <= 1'b0;
          err             <= 1'b0;
          busy            <= 1'b0;
          state_reg       <= IDLE;
        end
        default: begin
          mem_instr_valid <= 1'b0;
          err             <= 1'b0;
          busy            <= 1'b0;
          state_reg       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_backing_ctrl.sv
// Directed bench for imem_backing_ctrl: latency/strobe timing, range error,
// back-to-back pacing, write forwarding edges, and mid-flight reset.
module tb_imem_backing_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        mem_instr_valid;
  logic        busy;
  logic        err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] req_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;

  imem_backing_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORD_SIZE(4), .NUM_WORDS(1024),
    .LATENCY(LAT), .INIT_BASE(32'h10000000)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_instr(mem_instr), .mem_instr_valid(mem_instr_valid), .busy(busy),
    .err(err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_count(req_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from a negedge; optional write sampled at edge T0+wr_k.
  // Samples at each negedge after edges T0..T0+LAT+1.
  task automatic run_req(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int wr_k,
                         input logic [31:0] waddr, input logic [31:0] wdata);
    mem_req  = 1'b1;
    mem_addr = addr;
    @(posedge clk);
    exp_count = exp_count + 32'd1;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      check("busy", {31'd0, busy}, {31'd0, (k <= LAT)});
      check("valid", {31'd0, mem_instr_valid}, {31'd0, (k == LAT)});
      if (k == 0) check("req_count", req_count, exp_count);
      if (k == LAT) begin
        check("data", mem_instr, exp_data);
        check("err", {31'd0, err}, {31'd0, exp_err});
        mem_req = 1'b0;
      end
      if (k == LAT + 1) begin
        check("err_clear", {31'd0, err}, 32'd0);
        check("data_hold", mem_instr, exp_data);
      end
      if (wr_k >= 1 && k == wr_k - 1) begin
        wr_en = 1'b1; wr_addr = waddr; wr_data = wdata;
      end
      if (wr_k >= 1 && k == wr_k) wr_en = 1'b0;
    end
    $display("req addr=%h data=%h err=%0d count=%0d", addr, mem_instr, err, req_count);
  endtask

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_instr", mem_instr, 32'd0);
    check("rst_valid", {31'd0, mem_instr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_count", req_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic read of word 4
    run_req(32'h10, 32'h10000004, 1'b0, -1, 32'h0, 32'h0);

    // Out-of-range index then a normal read
    run_req(32'h1000, 32'h0, 1'b1, -1, 32'h0, 32'h0);
    run_req(32'h0, 32'h10000000, 1'b0, -1, 32'h0, 32'h0);

    // Held request: responses every LAT+2 cycles, one per acceptance
    mem_req = 1'b1; mem_addr = 32'h0;
    @(posedge clk);
    for (int c = 0; c <= 2 * (LAT + 2) + LAT + 1; c++) begin
      @(negedge clk);
      begin
        logic expv;
        expv = (c == LAT) || (c == LAT + (LAT + 2)) || (c == LAT + 2 * (LAT + 2));
        check("b2b_valid", {31'd0, mem_instr_valid}, {31'd0, expv});
        if (expv) check("b2b_data", mem_instr, 32'h10000000);
        if (c == LAT + 2 * (LAT + 2)) mem_req = 1'b0;
      end
    end
    exp_count = exp_count + 32'd3;
    check("b2b_count", req_count, exp_count);
    $display("b2b done count=%0d", req_count);

    // Write on the response-read edge returns old data, later read sees it
    run_req(32'h14, 32'h10000005, 1'b0, LAT, 32'h14, 32'hDEADBEEF);
    run_req(32'h14, 32'hDEADBEEF, 1'b0, -1, 32'h0, 32'h0);
    // Write during WAIT is forwarded to the response
    run_req(32'h14, 32'hCAFEF00D, 1'b0, 2, 32'h14, 32'hCAFEF00D);

    // Reset two cycles into WAIT aborts the request
    mem_req = 1'b1; mem_addr = 32'h20;
    @(posedge clk);
    repeat (3) @(negedge clk);
    mem_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_instr", mem_instr, 32'd0);
    check("mid_rst_valid", {31'd0, mem_instr_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_count", req_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 32'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_novalid", {31'd0, mem_instr_valid}, 32'd0);
    end
    $display("reset abort done");

    // Unaligned address maps to containing word
    run_req(32'h13, 32'h10000004, 1'b0, -1, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
